lvds_rx_deser: RTL
==================

// Module: lvds_rx_deser
// PURPOSE
//  7:1 LVDS receive deserializer and pixel decoder, the receive end of our dual-lane panel link.
//  Samples one clock lane and four data lanes at the bit rate, aligns on the 1100011 clock pattern,
//  unpacks VESA 24-bit words to {R,G,B}/HS/VS/DE, and regenerates x/y pixel coordinates.
//  Sits behind the input IO buffers; feeds loopback checkers and capture logic at clk_sys rate.
// PARAMETERS
//  LOCK_COUNT    8   consecutive good clock-lane words required to declare lock
//  UNLOCK_COUNT  4   consecutive bad clock-lane words while locked before dropping lock
//  XY_W          12  width of o_x / o_y counters
// PORTS
//  i_clk          in   1      bit-rate clock (clk_sys); one serial bit per lane per cycle
//  i_resetn       in   1      asynchronous, active-low reset
//  i_lvds_clk     in   1      sampled LVDS clock lane (treated as data)
//  i_lvds_data    in   4      sampled data lanes [3:0]
//  o_locked       out  1      word alignment locked
//  o_pix_valid    out  1      one-cycle strobe: o_color/o_hs/o_vs/o_de/o_x/o_y updated
//  o_color        out  24     {R[7:0],G[7:0],B[7:0]}
//  o_hs,o_vs,o_de out  1 each decoded sync/enable
//  o_x,o_y        out  XY_W   coordinate of pixel in o_color (valid when o_de=1)
//  o_err_count    out  16     clock-pattern mismatches while locked (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0; state SEARCH; shift regs, phase, good/bad counters 0.
//  Serial: bit6 of each word first; every lane shifts new bit into LSB of a 7-bit shift reg each cycle.
//  Lane map (bit6..0): L0={G0,R5..R0} L1={B1,B0,G5..G1} L2={DE,VS,HS,B5..B2} L3={x,B7,B6,G7,G6,R7,R6}.
//  Boundary: cycle where phase counter (0..6, wraps 6->0) == 6; words sampled from shift regs (incl. new bit).
//  FSM:
//   SEARCH: every cycle compare clock shift reg to 7'b1100011; on match load phase=6 alignment
//           (this cycle is a boundary), good=1, -> VERIFY.
//   VERIFY: at each boundary: match -> good++; good==LOCK_COUNT -> LOCKED; mismatch -> SEARCH, good=0.
//   LOCKED: o_locked=1. At boundary: match -> bad=0; mismatch -> bad++; bad==UNLOCK_COUNT -> SEARCH,
//           o_locked=0 next cycle. Mismatched words still decoded (single glitch tolerated).
//  Decode: at each LOCKED boundary, decoded fields registered; o_pix_valid high exactly the next cycle
//   (latency 1 cycle after boundary, 1 strobe per 7 cycles). Outputs hold between strobes.
//  No strobes outside LOCKED; on lock loss o_pix_valid forced 0 immediately, other outputs hold.
//  Coordinates (updated with each strobe, describing that pixel):
//   DE=1: o_x = x_cnt, x_cnt++ (wraps 2^XY_W-1 -> 0). o_y = y_cnt.
//   DE 1->0 (vs previous decoded word): x_cnt=0, y_cnt++ (wraps).
//   VS 0->1: y_cnt=0, x_cnt=0; VS rise and DE fall same word -> VS wins.
//   First word after (re)lock: previous DE/VS taken as 0; x_cnt, y_cnt reset to 0 on entering LOCKED.
//  Reset asserted mid-word: async clear of everything, realign from SEARCH after release.
// CONFIGURATION
//  LVDS_RX_STATS_EN defined: o_err_count increments on every LOCKED-state mismatch, saturates at 16'hFFFF,
//   cleared only by reset (not by lock loss).
//  Not defined: o_err_count tied to 16'h0000; no counter logic synthesized.
// TESTING
//  1. Reset, then clean stream, clock lane 1100011 repeating, all data 0 -> o_locked rises at 8th good
//     boundary; o_pix_valid every 7 cycles thereafter, 1 cycle after boundary.
//  2. Encode 24'hFF0000, DE=1 -> o_color=24'hFF0000, o_de=1; 24'h00FF00 and 24'h0000FF likewise.
//  3. Frame 958x1200 (VS pulse, DE lines) -> first pixel x=0,y=0; last x=957,y=1199; y resets on next VS.
//  4. Stream shifted by 3 bits -> relock with same decoded colors; one corrupted clock word while
//     locked -> lock held, o_err_count=1 (STATS_EN); 4 consecutive bad -> o_locked=0, strobes stop.
//  5. Random pattern never matching 1100011 -> o_locked stays 0, o_pix_valid never asserted.
//  6. i_resetn pulsed low mid-frame while locked -> all outputs 0 asynchronously; relock after release.

Source files
------------

// File: rtl/lvds_rx_deser.sv
// lvds_rx_deser: 7:1 LVDS receive deserializer, clock-pattern word aligner and VESA 24-bit pixel
// decoder with x/y regeneration. Define LVDS_RX_STATS_EN to build the o_err_count mismatch counter.
module lvds_rx_deser #(
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 4,
  parameter int XY_W         = 12
) (
  input  logic            i_clk,
  input  logic            i_resetn,
  input  logic            i_lvds_clk,
  input  logic [3:0]      i_lvds_data,
  output logic            o_locked,
  output logic            o_pix_valid,
  output logic [23:0]     o_color,
  output logic            o_hs,
  output logic            o_vs,
  output logic            o_de,
  output logic [XY_W-1:0] o_x,
  output logic [XY_W-1:0] o_y,
  output logic [15:0]     o_err_count,
  output logic [1:0]      o_dbg_state
);

  localparam logic [6:0] CLK_PATTERN = 7'b1100011;
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [GW-1:0] LOCK_C   = GW'(LOCK_COUNT);
  localparam logic [BW-1:0] UNLOCK_C = BW'(UNLOCK_COUNT);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // o_pix_valid is a one-cycle strobe with no back-pressure: downstream must accept the pixel
  // fields in the cycle o_pix_valid is high; the fields then hold until the next strobe.

  // Each lane keeps only the six previous bits; the current input bit completes the 7-bit word.
  // Lane 3 bit 6 carries no pixel data, so its history is one bit shorter.
  logic [5:0] ck_sr_q, ck_sr_d;
  logic [5:0] l0_sr_q, l0_sr_d;
  logic [5:0] l1_sr_q, l1_sr_d;
  logic [5:0] l2_sr_q, l2_sr_d;
  logic [4:0] l3_sr_q, l3_sr_d;

  logic [6:0] ck_word, l0_word, l1_word, l2_word;
  logic [5:0] l3_word;

  assign ck_sr_d = {ck_sr_q[4:0], i_lvds_clk};
  assign l0_sr_d = {l0_sr_q[4:0], i_lvds_data[0]};
  assign l1_sr_d = {l1_sr_q[4:0], i_lvds_data[1]};
  assign l2_sr_d = {l2_sr_q[4:0], i_lvds_data[2]};
  assign l3_sr_d = {l3_sr_q[3:0], i_lvds_data[3]};

  assign ck_word = {ck_sr_q, i_lvds_clk};
  assign l0_word = {l0_sr_q, i_lvds_data[0]};
  assign l1_word = {l1_sr_q, i_lvds_data[1]};
  assign l2_word = {l2_sr_q, i_lvds_data[2]};
  assign l3_word = {l3_sr_q, i_lvds_data[3]};

  logic [7:0] dec_r, dec_g, dec_b;
  logic       dec_hs, dec_vs, dec_de;

  assign dec_r  = {l3_word[1:0], l0_word[5:0]};
  assign dec_g  = {l3_word[3:2], l1_word[4:0], l0_word[6]};
  assign dec_b  = {l3_word[5:4], l2_word[3:0], l1_word[6:5]};
  assign dec_hs = l2_word[4];
  assign dec_vs = l2_word[5];
  assign dec_de = l2_word[6];

  state_e          state_q;
  logic [2:0]      phase_q, phase_d;
  logic [GW-1:0]   good_q, good_inc;
  logic [BW-1:0]   bad_q, bad_inc;
  logic            locked_q, pix_valid_q;
  logic [23:0]     color_q;
  logic            hs_q, vs_q, de_q;
  logic [XY_W-1:0] x_q, y_q;
  logic [XY_W-1:0] x_cnt_q, y_cnt_q;
  logic            prev_de_q, prev_vs_q;

  logic ck_match, boundary;

  assign ck_match = (ck_word == CLK_PATTERN);
  assign boundary = (phase_q == 3'd6);
  assign phase_d  = boundary ? 3'd0 : phase_q + 3'd1;
  assign good_inc = good_q + GW'(1);
  assign bad_inc  = bad_q + BW'(1);

  // Coordinate counters for the word being decoded; a VS rise overrides a DE fall.
  logic            vs_rise, de_fall;
  logic [XY_W-1:0] x_base, y_base, x_next;

  always_comb begin
    vs_rise = dec_vs & ~prev_vs_q;
    de_fall = ~dec_de & prev_de_q;
    x_base  = x_cnt_q;
    y_base  = y_cnt_q;
    if (vs_rise) begin
      x_base = '0;
      y_base = '0;
    end else if (de_fall) begin
      x_base = '0;
      y_base = y_cnt_q + XY_W'(1);
    end
    x_next = dec_de ? x_base + XY_W'(1) : x_base;
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      ck_sr_q     <= '0;
      l0_sr_q     <= '0;
      l1_sr_q     <= '0;
      l2_sr_q     <= '0;
      l3_sr_q     <= '0;
      state_q     <= ST_SEARCH;
      phase_q     <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      locked_q    <= 1'b0;
      pix_valid_q <= 1'b0;
      color_q     <= '0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      de_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      prev_de_q   <= 1'b0;
      prev_vs_q   <= 1'b0;
    end else begin
      ck_sr_q     <= ck_sr_d;
      l0_sr_q     <= l0_sr_d;
      l1_sr_q     <= l1_sr_d;
      l2_sr_q     <= l2_sr_d;
      l3_sr_q     <= l3_sr_d;
      phase_q     <= phase_d;
      pix_valid_q <= 1'b0;
      case (state_q)
        ST_SEARCH: begin
          // A match here marks this cycle as a word boundary, so the next cycle is phase 0.
          if (ck_match) begin
            phase_q <= 3'd0;
            good_q  <= GW'(1);
            state_q <= ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (boundary) begin
            if (ck_match) begin
              if (good_inc == LOCK_C) begin
                state_q   <= ST_LOCKED;
                locked_q  <= 1'b1;
                good_q    <= '0;
                bad_q     <= '0;
                x_cnt_q   <= '0;
                y_cnt_q   <= '0;
                prev_de_q <= 1'b0;
                prev_vs_q <= 1'b0;
              end else begin
                good_q <= good_inc;
              end
            end else begin
              state_q <= ST_SEARCH;
              good_q  <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (boundary) begin
            if (!ck_match && (bad_inc == UNLOCK_C)) begin
              state_q  <= ST_SEARCH;
              locked_q <= 1'b0;
              bad_q    <= '0;
            end else begin
              // Isolated bad clock words are tolerated and their data is still decoded.
              bad_q       <= ck_match ? '0 : bad_inc;
              pix_valid_q <= 1'b1;
              color_q     <= {dec_r, dec_g, dec_b};
              hs_q        <= dec_hs;
              vs_q        <= dec_vs;
              de_q        <= dec_de;
              x_q         <= x_base;
              y_q         <= y_base;
              x_cnt_q     <= x_next;
              y_cnt_q     <= y_base;
              prev_de_q   <= dec_de;
              prev_vs_q   <= dec_vs;
            end
          end
        end
        default: begin
          state_q  <= ST_SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef LVDS_RX_STATS_EN
  logic [15:0] err_cnt_q;
  logic        err_hit;

  assign err_hit = (state_q == ST_LOCKED) && boundary && !ck_match;

  // Survives lock loss on purpose: only reset clears the link-quality history.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      err_cnt_q <= '0;
    end else if (err_hit && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign o_err_count = err_cnt_q;
`else
  assign o_err_count = 16'h0000;
`endif

  assign o_locked    = locked_q;
  assign o_pix_valid = pix_valid_q;
  assign o_color     = color_q;
  assign o_hs        = hs_q;
  assign o_vs        = vs_q;
  assign o_de        = de_q;
  assign o_x         = x_q;
  assign o_y         = y_q;
  assign o_dbg_state = state_q;

endmodule
